// File: rtl/slc3_mem_pkg.sv
// Shared types and boot image for the SLC-3 SRAM responder.
//   state_t   : responder FSM states (INIT copies the boot image, READY serves the bus)
//   PROG_LEN  : number of words in the boot image; words beyond it boot to zero
//   prog_rom  : boot image lookup by word index
package slc3_mem_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int PROG_LEN = 3;

  // 0: CLR R0   1: LDR R1,R0,inSW   2: JMP R1
  function automatic logic [15:0] prog_rom(input logic [31:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    if (idx < 32'(PROG_LEN)) begin
      case (idx)
        32'd0:   w = 16'h5020;
        32'd1:   w = 16'h623F;
        32'd2:   w = 16'hC040;
        default: w = 16'h0000;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// SLC-3 external SRAM control bus (all strobes active-low).
//   CE   chip enable          UB/LB  upper/lower byte lane enables
//   OE   output enable        WE     write enable
//   ADDR word address
// The shared 16-bit data bus is a plain inout on the responder.
// master: the CPU side drives everything; slave: the responder samples it.
interface sram_responder_if #(parameter int ADDR_W = 20);
  logic              CE;
  logic              UB;
  logic              LB;
  logic              OE;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;

  modport master (output CE, UB, LB, OE, WE, ADDR);
  modport slave  (input  CE, UB, LB, OE, WE, ADDR);
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the DE2 external SRAM, responder end of the SLC-3 bus.
// After reset it copies the boot image into its array (2**DEPTH_LOG2 cycles),
// then serves byte-lane reads (1-cycle latency) and writes.
//   Clk        system clock, rising edge
//   Reset      asynchronous active-low; restarts the boot copy
//   bus        CE/UB/LB/OE/WE/ADDR control bus (slave side)
//   Data       shared 16-bit data bus; driven only during an established read
//   Init_Done  high once the boot copy has finished
//   Addr_Err   one-cycle pulse after an out-of-range access while READY
module sram_responder
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  sram_responder_if.slave    bus,
  inout  wire  [15:0]        Data,
  output logic               Init_Done,
  output logic               Addr_Err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_mem [DEPTH];
  logic [15:0]           r_mem_q;
  logic                  r_zero_q;
  logic                  r_drv_q;
  logic                  r_addr_err;

  logic                  w_ready, w_rd, w_wr, w_oob;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [1:0]            w_be;
  logic [15:0]           w_wdata;
  logic [15:0]           w_rd_q;

  assign w_ready = (r_state == READY);
  assign w_oob   = (bus.ADDR[ADDR_W-1:DEPTH_LOG2] != '0);
  assign w_rd    = w_ready & ~bus.CE & ~bus.OE &  bus.WE;
  // A write beats OE, so CE+OE+WE all low never turns the data driver on.
  assign w_wr    = w_ready & ~bus.CE & ~bus.WE;

  always_comb begin
    w_state_nxt = r_state;
    Init_Done   = 1'b0;
    case (r_state)
      INIT:    if (&r_idx) w_state_nxt = READY;
      READY: begin
        w_state_nxt = READY;
        Init_Done   = 1'b1;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= INIT;
      r_idx      <= '0;
      r_drv_q    <= 1'b0;
      r_zero_q   <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == INIT) r_idx <= r_idx + 1'b1;
      r_drv_q    <= w_rd;
      r_zero_q   <= w_oob;
      r_addr_err <= (w_rd | w_wr) & w_oob;
    end
  end

  // Single RAM port: the boot counter owns it during INIT, the bus afterwards.
  // Out-of-range writes are dropped by clearing both lane enables.
  always_comb begin
    w_addr  = r_idx;
    w_wdata = prog_rom(32'(r_idx));
    w_be    = 2'b11;
    if (w_ready) begin
      w_addr  = bus.ADDR[DEPTH_LOG2-1:0];
      w_wdata = Data;
      w_be    = (w_wr & ~w_oob) ? {~bus.UB, ~bus.LB} : 2'b00;
    end
  end

  // No reset on the array so it maps onto a byte-enabled block RAM.
  always_ff @(posedge Clk) begin
    if (w_be[1]) r_mem[w_addr][15:8] <= w_wdata[15:8];
    if (w_be[0]) r_mem[w_addr][7:0]  <= w_wdata[7:0];
    r_mem_q <= r_mem[w_addr];
  end

  // Out-of-range reads (and the reset state) return zero.
  assign w_rd_q = r_zero_q ? 16'h0000 : r_mem_q;

  // Drive needs a read on the previous edge and still now; dropping rd releases
  // the bus in the same cycle.
  assign Data[15:8] = (r_drv_q & w_rd & ~bus.UB) ? w_rd_q[15:8] : 8'hzz;
  assign Data[7:0]  = (r_drv_q & w_rd & ~bus.LB) ? w_rd_q[7:0]  : 8'hzz;

  assign Addr_Err = r_addr_err;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: boot timing, directed vector table, reset during
// boot, and random bus traffic against an array-based reference model.
// Data carries a pullup, so an undriven byte lane reads as 8'hFF.
module tb_sram_responder;

  localparam int DL2   = 10;
  localparam int AW    = 20;
  localparam int DEPTH = 1 << DL2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Init_Done, Addr_Err;
  wire  [15:0] Data;
  logic        tb_drv;
  logic [15:0] tb_dat;

  sram_responder_if #(.ADDR_W(AW)) bus();

  assign Data = tb_drv ? tb_dat : 16'hzzzz;
  pullup (Data);

  sram_responder #(.DEPTH_LOG2(DL2), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave), .Data(Data),
    .Init_Done(Init_Done), .Addr_Err(Addr_Err)
  );

  always #5 Clk = ~Clk;

  int          n_run, n_fail;
  logic [15:0] m [DEPTH];
  bit          prev_rd;
  logic [15:0] prev_val;

  typedef struct {
    bit          ce, ub, lb, oe, we;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_d;
    bit          exp_e;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_boot();
    for (int i = 0; i < DEPTH; i++) m[i] = 16'h0000;
    m[0] = 16'h5020; m[1] = 16'h623F; m[2] = 16'hC040;
    prev_rd  = 0;
    prev_val = 16'h0000;
  endtask

  task automatic idle();
    bus.CE = 1; bus.UB = 1; bus.LB = 1; bus.OE = 1; bus.WE = 1;
    bus.ADDR = '0; tb_drv = 0; tb_dat = 16'h0000;
  endtask

  // One bus cycle, entered 1ns after a rising edge. Data is sampled mid-cycle,
  // Addr_Err 1ns after the closing edge. The model predicts both.
  task automatic cyc(input bit ce, ub, lb, oe, we, input logic [AW-1:0] a,
                     input logic [15:0] wd, output logic [15:0] got_d,
                     output logic got_e, output logic [15:0] md, output bit me);
    bit rd, wr, oob;
    int idx;
    bus.CE = ce; bus.UB = ub; bus.LB = lb; bus.OE = oe; bus.WE = we;
    bus.ADDR = a; tb_drv = !we; tb_dat = wd;
    rd  = !ce && !oe && we;
    wr  = !ce && !we;
    oob = (a >> DL2) != 0;
    idx = int'(a % DEPTH);
    md  = !we ? wd : 16'hFFFF;
    if (rd && prev_rd) begin
      if (!ub) md[15:8] = prev_val[15:8];
      if (!lb) md[7:0]  = prev_val[7:0];
    end
    #4 got_d = Data;
    @(posedge Clk); #1 got_e = Addr_Err;
    me       = (rd || wr) && oob;
    prev_rd  = rd;
    prev_val = oob ? 16'h0000 : m[idx];
    if (wr && !oob) begin
      if (!ub) m[idx][15:8] = wd[15:8];
      if (!lb) m[idx][7:0]  = wd[7:0];
    end
  endtask

  // Release reset and watch the full boot while a read to an out-of-range
  // address is held on the bus (INIT must ignore it).
  task automatic boot(input string tag);
    bus.CE = 0; bus.OE = 0; bus.WE = 1; bus.UB = 0; bus.LB = 0;
    bus.ADDR = 20'h00400; tb_drv = 0;
    Reset = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge Clk); #1;
      if (k == DEPTH - 1 || k == DEPTH) chk({tag, "_done_edge"}, 32'(Init_Done), 32'(k == DEPTH));
      else if (Init_Done !== 1'b0) chk({tag, "_done_low"}, 32'(Init_Done), 0);
      if (k < DEPTH && (k % 128) == 1) begin
        chk({tag, "_data_z"}, 32'(Data), 32'hFFFF);
        chk({tag, "_err_low"}, 32'(Addr_Err), 0);
      end
    end
    idle();
    model_boot();
  endtask

  task automatic add(input bit ce, ub, lb, oe, we, input logic [19:0] a,
                     input logic [15:0] wd, ed, input bit ee);
    vec_t v;
    v.ce = ce; v.ub = ub; v.lb = lb; v.oe = oe; v.we = we;
    v.addr = a; v.wd = wd; v.exp_d = ed; v.exp_e = ee;
    tv.push_back(v);
  endtask

  initial begin
    logic [15:0] gd, md;
    logic        ge;
    bit          me;
    logic [AW-1:0] ra;
    n_run = 0; n_fail = 0;
    idle();
    model_boot();
    Reset = 0;

    //          ce ub lb oe we addr      wdata    Data     err
    add(0, 0, 0, 0, 1, 20'h00000, 16'h0000, 16'hFFFF, 0); // first read: not yet driven
    add(0, 0, 0, 0, 1, 20'h00000, 16'h0000, 16'h5020, 0);
    add(0, 0, 0, 0, 1, 20'h00002, 16'h0000, 16'h5020, 0); // 1-cycle latency
    add(0, 0, 0, 0, 1, 20'h00002, 16'h0000, 16'hC040, 0);
    add(0, 0, 0, 1, 0, 20'h00010, 16'hBEEF, 16'hBEEF, 0);
    add(0, 1, 0, 1, 0, 20'h00010, 16'h0012, 16'h0012, 0); // lower lane only
    add(0, 0, 0, 0, 1, 20'h00010, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 0, 0, 1, 20'h00010, 16'h0000, 16'hBE12, 0);
    add(0, 0, 1, 0, 1, 20'h00010, 16'h0000, 16'hBEFF, 0); // upper lane read
    add(0, 0, 0, 0, 1, 20'h00400, 16'h0000, 16'hBE12, 1);
    add(0, 0, 0, 0, 1, 20'h00400, 16'h0000, 16'h0000, 1); // oob reads zero
    add(1, 0, 0, 0, 1, 20'h00000, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 0, 1, 0, 20'h00400, 16'hAAAA, 16'hAAAA, 1); // oob write dropped
    add(1, 1, 1, 1, 1, 20'h00000, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 0, 0, 1, 20'h00000, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 0, 0, 1, 20'h00000, 16'h0000, 16'h5020, 0);
    add(0, 0, 0, 0, 0, 20'h00020, 16'h1234, 16'h1234, 0); // OE+WE: write wins
    add(0, 0, 0, 0, 1, 20'h00020, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 0, 0, 1, 20'h00020, 16'h0000, 16'h1234, 0);
    add(0, 0, 0, 1, 1, 20'h00020, 16'h0000, 16'hFFFF, 0); // OE dropped: release now
    add(1, 0, 0, 0, 1, 20'h00020, 16'h0000, 16'hFFFF, 0);

    repeat (2) @(posedge Clk);
    #1;
    bus.CE = 0; bus.OE = 0; bus.ADDR = 20'h00400; #1;
    chk("rst_done", 32'(Init_Done), 0);
    chk("rst_err", 32'(Addr_Err), 0);
    chk("rst_data_z", 32'(Data), 32'hFFFF);
    boot("boot1");

    foreach (tv[i]) begin
      cyc(tv[i].ce, tv[i].ub, tv[i].lb, tv[i].oe, tv[i].we, tv[i].addr, tv[i].wd, gd, ge, md, me);
      chk($sformatf("vec%0d_data", i), 32'(gd), 32'(tv[i].exp_d));
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(tv[i].exp_e));
    end

    // Reset during boot must abort and restore the boot image.
    cyc(0, 0, 0, 1, 0, 20'h00000, 16'hFFFF, gd, ge, md, me);
    cyc(0, 0, 0, 0, 1, 20'h00000, 16'h0000, gd, ge, md, me);
    cyc(0, 0, 0, 0, 1, 20'h00000, 16'h0000, gd, ge, md, me);
    chk("t6_written", 32'(gd), 32'hFFFF);
    idle();
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1;
    for (int k = 1; k <= 500; k++) begin
      @(posedge Clk); #1;
      if (Init_Done !== 1'b0) chk("t6_mid_done", 32'(Init_Done), 0);
    end
    chk("t6_mid_done500", 32'(Init_Done), 0);
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1 chk("t6_rst_done", 32'(Init_Done), 0);
    boot("boot2");
    cyc(0, 0, 0, 0, 1, 20'h00000, 16'h0000, gd, ge, md, me);
    cyc(0, 0, 0, 0, 1, 20'h00000, 16'h0000, gd, ge, md, me);
    chk("t6_reboot_read", 32'(gd), 32'h5020);

    // Random traffic on a small window plus occasional out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)
        ra = {10'($urandom_range(1, 1023)), 10'($urandom_range(0, 15))};
      else
        ra = 20'($urandom_range(0, 15));
      cyc($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
          16'($urandom), gd, ge, md, me);
      chk($sformatf("rnd%0d_data", n), 32'(gd), 32'(md));
      chk($sformatf("rnd%0d_err", n), 32'(ge), 32'(me));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
